// File: rtl/alu_display_if.sv
// ALU result / op-select input bus plus the multiplexed 7-segment outputs.
// Latency: none, wires only.
// Backpressure: none; busy is informational and inputs are sampled when idle.
interface alu_display_if;
  logic [7:0] Y;
  logic [1:0] S;
  logic [3:0] an;
  logic [6:0] seg;
  logic       busy;

  modport master (output Y, output S, input an, input seg, input busy);
  modport slave  (input Y, input S, output an, output seg, output busy);
endinterface

// File: rtl/alu_display.sv
// Captures the ALU result, converts it to 3 BCD digits and scans them plus the op code.
// Latency: binary modes commit 9 edges after capture, BCD mode commits 1 edge after capture.
// Backpressure: input changes while busy are ignored; the latest value is picked up back in IDLE.
module alu_display #(
  parameter int REFRESH_DIV = 50000
) (
  input logic          clk,
  input logic          rst,
  alu_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state, next_state;
  logic [9:0]    last_cap;
  logic          pending;
  logic          capture_req;
  logic          capture, shift_en, commit;
  logic [1:0]    cap_s;
  logic [7:0]    bin;
  logic [11:0]   bcd, bcd_adj;
  logic [3:0]    shift_cnt;
  logic [3:0]    disp_h, disp_t, disp_o;
  logic [1:0]    disp_s;
  logic          disp_vld;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [6:0]    seg_nxt;
  logic          busy_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = DASH;
    endcase
  endfunction

  // The pending flag forces one capture after reset even if inputs equal the reset snapshot.
  assign capture_req = ({bus.Y, bus.S} != last_cap) || pending;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next state: BCD input skips the conversion, binary needs 8 shift edges.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture_req) next_state = (bus.S == 2'b10) ? DONE : CONV;
      CONV:    if (shift_cnt == 4'd7) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes decoded from the current state.
  always_comb begin
    capture  = (state == IDLE) && capture_req;
    shift_en = (state == CONV);
    commit   = (state == DONE);
  end

  // busy is registered from the next state so it is high exactly during CONV and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (next_state != IDLE);
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more before shifting.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Capture snapshot and run the shift-add-3 conversion; BCD mode loads its digits directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cap  <= '0;
      pending   <= 1'b1;
      cap_s     <= '0;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (capture) begin
      last_cap  <= {bus.Y, bus.S};
      pending   <= 1'b0;
      cap_s     <= bus.S;
      shift_cnt <= '0;
      if (bus.S == 2'b10) begin
        bcd <= {4'h0, 3'b000, bus.Y[4], bus.Y[3:0]};
        bin <= '0;
      end else begin
        bcd <= '0;
        bin <= bus.Y;
      end
    end else if (shift_en) begin
      {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
      shift_cnt  <= shift_cnt + 4'd1;
    end
  end

  // Display registers change only in DONE, all digits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_h   <= '0;
      disp_t   <= '0;
      disp_o   <= '0;
      disp_s   <= '0;
      disp_vld <= 1'b0;
    end else if (commit) begin
      disp_h   <= bcd[11:8];
      disp_t   <= bcd[7:4];
      disp_o   <= bcd[3:0];
      disp_s   <= cap_s;
      disp_vld <= 1'b1;
    end
  end

  // Refresh counter; each wrap advances the lit digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Pattern for the current digit; zero blanking never hides a dash since a dash digit is nonzero.
  always_comb begin
    seg_nxt = BLANK;
    if (disp_vld) begin
      case (idx)
        2'd0:    seg_nxt = seg7(disp_o);
        2'd1:    seg_nxt = (disp_h == 4'd0 && disp_t == 4'd0) ? BLANK : seg7(disp_t);
        2'd2:    seg_nxt = (disp_h == 4'd0) ? BLANK : seg7(disp_h);
        default: seg_nxt = seg7({2'b00, disp_s});
      endcase
    end
  end

  // Registered anode and cathode drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= BLANK;
    end else begin
      an_q  <= ~(4'b0001 << idx);
      seg_q <= seg_nxt;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_alu_display.sv
// Directed bench for alu_display with a 4-cycle refresh divider.
// Latency: checks busy lengths and commit timing against hand-computed cycle counts.
// Backpressure: exercises input changes while busy, which must be deferred, not lost.
module tb_alu_display;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  alu_display_if ifc ();

  alu_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Collects one full scan worth of segment patterns, indexed by the lit digit.
  task automatic get_digits(output logic [6:0] d0, output logic [6:0] d1,
                            output logic [6:0] d2, output logic [6:0] d3);
    d0 = 'x; d1 = 'x; d2 = 'x; d3 = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      case (ifc.an)
        4'b1110: d0 = ifc.seg;
        4'b1101: d1 = ifc.seg;
        4'b1011: d2 = ifc.seg;
        4'b0111: d3 = ifc.seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    int n;
    logic [6:0] d0, d1, d2, d3;
    ifc.Y = 8'h00; ifc.S = 2'b00;
    repeat (3) @(negedge clk);
    total++; if (ifc.an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", ifc.an); end
    total++; if (ifc.seg !== BL) begin bad++; $display("FAIL reset_seg got=%b want=%b", ifc.seg, BL); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ifc.an !== 4'b1110) begin bad++; $display("FAIL first_an got=%b want=1110", ifc.an); end
    total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL first_capture_busy got=%b want=1", ifc.busy); end
    total++; if (ifc.seg !== BL) begin bad++; $display("FAIL first_seg_blank got=%b want=%b", ifc.seg, BL); end
    n = 1;
    for (int i = 0; i < 30 && ifc.busy === 1'b1; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) n++;
    end
    total++; if (n != 9) begin bad++; $display("FAIL reset_busy_len got=%0d want=9", n); end
    get_digits(d0, d1, d2, d3);
    total++; if (d0 !== P0) begin bad++; $display("FAIL zero_d0 got=%b want=%b", d0, P0); end
    total++; if (d1 !== BL) begin bad++; $display("FAIL zero_d1 got=%b want=%b", d1, BL); end
    total++; if (d2 !== BL) begin bad++; $display("FAIL zero_d2 got=%b want=%b", d2, BL); end
    total++; if (d3 !== P0) begin bad++; $display("FAIL zero_d3 got=%b want=%b", d3, P0); end
  endtask

  task automatic test_binary_ff;
    int n;
    logic [6:0] d0, d1, d2, d3;
    @(negedge clk);
    ifc.Y = 8'hFF; ifc.S = 2'b00;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) n++;
      else if (n > 0) break;
    end
    total++; if (n != 9) begin bad++; $display("FAIL ff_busy_len got=%0d want=9", n); end
    get_digits(d0, d1, d2, d3);
    total++; if (d0 !== P5) begin bad++; $display("FAIL ff_d0 got=%b want=%b", d0, P5); end
    total++; if (d1 !== P5) begin bad++; $display("FAIL ff_d1 got=%b want=%b", d1, P5); end
    total++; if (d2 !== P2) begin bad++; $display("FAIL ff_d2 got=%b want=%b", d2, P2); end
    total++; if (d3 !== P0) begin bad++; $display("FAIL ff_d3 got=%b want=%b", d3, P0); end
  endtask

  task automatic test_bcd(input logic [7:0] y, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2);
    int n;
    logic [6:0] d0, d1, d2, d3;
    @(negedge clk);
    ifc.Y = y; ifc.S = 2'b10;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) n++;
      else if (n > 0) break;
    end
    total++; if (n != 1) begin bad++; $display("FAIL bcd_%h_busy_len got=%0d want=1", y, n); end
    get_digits(d0, d1, d2, d3);
    total++; if (d0 !== e0) begin bad++; $display("FAIL bcd_%h_d0 got=%b want=%b", y, d0, e0); end
    total++; if (d1 !== e1) begin bad++; $display("FAIL bcd_%h_d1 got=%b want=%b", y, d1, e1); end
    total++; if (d2 !== e2) begin bad++; $display("FAIL bcd_%h_d2 got=%b want=%b", y, d2, e2); end
    total++; if (d3 !== P2) begin bad++; $display("FAIL bcd_%h_d3 got=%b want=%b", y, d3, P2); end
  endtask

  // C8 in multiply mode, then 07 arrives during the 3rd CONV cycle. Sample i follows edge k+i-1.
  task automatic test_skip;
    logic [6:0] e_old [4];
    logic [6:0] e_200 [4];
    logic [6:0] e_7 [4];
    logic [6:0] want;
    logic exp_busy;
    int dig;
    e_old[0] = DS; e_old[1] = BL; e_old[2] = BL; e_old[3] = P2;
    e_200[0] = P0; e_200[1] = P0; e_200[2] = P2; e_200[3] = P3;
    e_7[0] = P7;   e_7[1] = BL;   e_7[2] = BL;   e_7[3] = P3;
    for (int i = 0; i < 20 && ifc.an !== 4'b0111; i++) @(negedge clk);
    for (int i = 0; i < 20 && ifc.an !== 4'b1110; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    ifc.Y = 8'hC8; ifc.S = 2'b11;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      exp_busy = (i <= 9) || (i >= 11 && i <= 19);
      total++;
      if (ifc.busy !== exp_busy) begin
        bad++; $display("FAIL skip_busy sample=%0d got=%b want=%b", i, ifc.busy, exp_busy);
      end
      case (ifc.an)
        4'b1110: dig = 0;
        4'b1101: dig = 1;
        4'b1011: dig = 2;
        4'b0111: dig = 3;
        default: dig = -1;
      endcase
      total++;
      if (dig < 0) begin
        bad++; $display("FAIL skip_an_onehot sample=%0d got=%b want=one low bit", i, ifc.an);
      end else begin
        want = (i <= 10) ? e_old[dig] : (i <= 20) ? e_200[dig] : e_7[dig];
        if (ifc.seg !== want) begin
          bad++; $display("FAIL skip_seg sample=%0d digit=%0d got=%b want=%b", i, dig, ifc.seg, want);
        end
      end
      if (i == 3) ifc.Y = 8'h07;
    end
  endtask

  task automatic test_scan;
    logic [3:0] cur;
    int n;
    cur = ifc.an;
    for (int i = 0; i < 20 && ifc.an === cur; i++) @(negedge clk);
    cur = ifc.an;
    for (int step = 0; step < 4; step++) begin
      n = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ifc.an === cur) n++;
        else break;
      end
      total++; if (n != 4) begin bad++; $display("FAIL scan_hold an=%b got=%0d want=4", cur, n); end
      total++;
      if (ifc.an !== {cur[2:0], cur[3]}) begin
        bad++; $display("FAIL scan_step from=%b got=%b want=%b", cur, ifc.an, {cur[2:0], cur[3]});
      end
      cur = ifc.an;
    end
  endtask

  task automatic test_reset_mid_conv;
    int n_busy, n_lit;
    logic [6:0] d0, d1, d2, d3;
    @(negedge clk);
    ifc.Y = 8'h55; ifc.S = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (ifc.an !== 4'b1111) begin bad++; $display("FAIL midrst_an got=%b want=1111", ifc.an); end
    total++; if (ifc.seg !== BL) begin bad++; $display("FAIL midrst_seg got=%b want=%b", ifc.seg, BL); end
    total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", ifc.busy); end
    @(negedge clk);
    rst = 1'b0;
    n_busy = 0; n_lit = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) n_busy++;
      if (i <= 10 && ifc.seg !== BL) n_lit++;
    end
    total++; if (n_busy != 9) begin bad++; $display("FAIL midrst_busy_len got=%0d want=9", n_busy); end
    total++; if (n_lit != 0) begin bad++; $display("FAIL midrst_blank lit_samples=%0d want=0", n_lit); end
    get_digits(d0, d1, d2, d3);
    total++; if (d0 !== P5) begin bad++; $display("FAIL r85_d0 got=%b want=%b", d0, P5); end
    total++; if (d1 !== P8) begin bad++; $display("FAIL r85_d1 got=%b want=%b", d1, P8); end
    total++; if (d2 !== BL) begin bad++; $display("FAIL r85_d2 got=%b want=%b", d2, BL); end
    total++; if (d3 !== P1) begin bad++; $display("FAIL r85_d3 got=%b want=%b", d3, P1); end
  endtask

  initial begin
    ifc.Y = 8'h00;
    ifc.S = 2'b00;
    test_reset();
    test_binary_ff();
    test_bcd(8'h13, P3, P1, BL);
    test_bcd(8'h0C, DS, BL, BL);
    test_skip();
    test_scan();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_display.md
ALU_DISPLAY -- requirements
Module: alu_display

Interface
REQ-001 The block SHALL have one parameter: REFRESH_DIV, default 50000, which is the number of clk cycles each digit is lit (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Y, input, 8 bits: the ALU result word, downstream of the ALU.
REQ-005 The block SHALL have port S, input, 2 bits: the ALU op select (00 buffer, 01 binary add/sub, 10 BCD add, 11 multiply).
REQ-006 The block SHALL have port an, output, 4 bits: active-low one-hot digit enables, where an[0] is the rightmost digit.
REQ-007 The block SHALL have port seg, output, 7 bits: active-low cathodes ordered {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a conversion is in flight.

Function
REQ-009 The block SHALL use a 3-state FSM: IDLE, CONV and DONE.
REQ-010 In IDLE, the block SHALL capture Y and S when ({Y,S} differs from the last captured value) or the pending flag is set.
  - The capture SHALL clear the pending flag.
  - If S==10, the next state SHALL be DONE.
  - Otherwise, the next state SHALL be CONV.
REQ-011 In CONV, the block SHALL run a binary-to-BCD shift-add-3 (double-dabble) conversion.
  - Each edge SHALL perform one shift: add 3 to every BCD nibble that is ≥5, then shift left 1.
  - Exactly 8 shifts SHALL be performed, and the state SHALL then be DONE.
  - The result SHALL be 3 digits: H (0-2), T and O.
REQ-012 For BCD mode (S==10), the digits SHALL be taken directly at capture.
  - O = Y[3:0].
  - T = {3'b000, Y[4]}.
  - H = 0.
REQ-013 In DONE, the block SHALL commit H, T, O and the captured S to the display registers in one edge, and then return to IDLE.
  - The display registers SHALL change only in DONE; there are no partial updates.
REQ-014 Latency SHALL be as follows, with capture at edge k:
  - Binary modes: commit at edge k+9.
  - BCD mode: commit at edge k+1.
REQ-015 busy SHALL be registered and high exactly while the state is CONV or DONE (9 cycles for binary modes, 1 cycle for BCD mode).
REQ-016 Y/S changes while busy SHALL be ignored until the return to IDLE.
  - The next IDLE cycle SHALL compare against the last capture, so the latest value is always eventually shown.
  - Intermediate values MAY be skipped.
REQ-017 The rendering of each digit SHALL be as follows:
  - Digit 0 (an[0]) SHALL show O.
  - Digit 1 SHALL show T, blanked when H==0 and T==0.
  - Digit 2 SHALL show H, blanked when H==0.
  - Digit 3 SHALL show the committed S as a numeral 0-3.
REQ-018 Any digit value >9 (invalid BCD input) SHALL render as a dash (7'b0111111), and leading-zero blanking SHALL then not apply to that digit.
REQ-019 The digit patterns SHALL be:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - blank = 1111111
REQ-020 Scanning SHALL use a refresh counter running 0..REFRESH_DIV-1.
  - On wrap, the 2-bit digit index SHALL increment, wrapping 3→0.
REQ-021 an and seg SHALL be registered from the current index and the display registers.
  - an SHALL have exactly one bit low at all times outside reset.

Reset
REQ-022 While rst is high, the outputs SHALL be an=1111, seg=1111111, busy=0.
REQ-023 While rst is high, the internal state SHALL be: FSM=IDLE, refresh counter=0, digit index=0, display registers blank, last capture=0, pending flag=1.
REQ-024 The first edge after rst deasserts SHALL drive an=1110.
  - It SHALL also capture the current Y/S unconditionally, via the pending flag.
REQ-025 A reset asserted mid-CONV SHALL abort the conversion; the display SHALL stay blank until the post-reset conversion commits.

Verification (REFRESH_DIV=4 in simulation)
REQ-026 The bench SHALL cover: Reset, then release with Y=00, S=00 → busy high for 9 cycles; then digit0=1000000, digit1 and digit2 blank, digit3=1000000.
REQ-027 The bench SHALL cover: Y=FF, S=00 → after 9 edges digits H,T,O = 0100100, 0010010, 0010010; digit3=1000000.
REQ-028 The bench SHALL cover: Y=13, S=10 → busy for 1 cycle; O=0110000, T=1111001, H blank, digit3=0100100.
REQ-029 The bench SHALL cover: Y=0C, S=10 → O=dash, T and H blank.
REQ-030 The bench SHALL cover: Y=C8 (200), S=11, then Y=07 at the 3rd CONV cycle → the display shows 200 (H=2, T=0 unblanked, O=0), then 7 with H and T blank, with no other value committed in between.
REQ-031 The bench SHALL cover: a full scan with a fixed value → an steps 1110→1101→1011→0111→1110, each step held for exactly 4 cycles.
